// File: rtl/spi_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | spi_pkg : shared types and constants for the SPI register port     |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } spi_state_t;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | spi_sync_edge : multi-flop synchroniser with rise/fall pulses      |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic i_ena,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else if (i_ena) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  // Pulses are masked while disabled so a frozen chain never re-fires.
  assign o_rise  = i_ena &  o_level & ~r_prev;
  assign o_fall  = i_ena & ~o_level &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_burst.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | spi_reg_burst : SPI slave register port, burst with auto-increment |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module spi_reg_burst
  import spi_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int REG_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ena,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_i,
  output logic [REG_W-1:0]  reg_data_o,
  output logic              reg_data_o_dv,
  input  logic [7:0]        status,
  output logic              busy
);

  localparam int CNT_W = $clog2(REG_W) + 1;

  logic w_clk_rise, w_clk_fall, w_sof, w_eof, w_mosi;
  logic w_unused_clk_level, w_unused_cs_level, w_unused_mosi_rise, w_unused_mosi_fall;
  logic w_sample, w_change;
  logic [REG_W-1:0] w_rx_next;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rstb(rstb), .i_ena(ena), .i_d(spi_clk),
    .o_level(w_unused_clk_level), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rstb(rstb), .i_ena(ena), .i_d(spi_cs_n),
    .o_level(w_unused_cs_level), .o_rise(w_eof), .o_fall(w_sof)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rstb(rstb), .i_ena(ena), .i_d(spi_mosi),
    .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall)
  );

  assign w_sample  = (cpol == cpha) ? w_clk_rise : w_clk_fall;
  assign w_change  = (cpol == cpha) ? w_clk_fall : w_clk_rise;

  spi_state_t         r_state;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [REG_W-1:0]   r_rx;
  logic [REG_W-1:0]   r_tx;
  logic               r_first_seen;
  logic               r_word_done;
  logic               r_inc_pend;
  logic [ADDR_W-1:0]  r_addr;
  logic [REG_W-1:0]   r_data_o;
  logic               r_dv;
  logic               r_busy;

  assign w_rx_next = {r_rx[REG_W-2:0], w_mosi};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state      <= IDLE;
      r_bitcnt     <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_first_seen <= 1'b0;
      r_word_done  <= 1'b0;
      r_inc_pend   <= 1'b0;
      r_addr       <= '0;
      r_data_o     <= '0;
      r_dv         <= 1'b0;
      r_busy       <= 1'b0;
    end else if (ena) begin
      r_dv       <= 1'b0;
      r_inc_pend <= 1'b0;
      // A completed write or a read load advances the address regardless of eof.
      if (r_dv || r_inc_pend)
        r_addr <= r_addr + ADDR_W'(1);

      if (w_eof) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_bitcnt    <= '0;
        r_word_done <= 1'b0;
      end else begin
        if (w_change && r_state != IDLE) begin
          r_first_seen <= 1'b1;
          if (!(cpha && !r_first_seen)) begin
            if (r_word_done) begin
              r_tx        <= reg_data_i;
              r_word_done <= 1'b0;
              r_inc_pend  <= 1'b1;
            end else begin
              r_tx <= {r_tx[REG_W-2:0], 1'b0};
            end
          end
        end

        case (r_state)
          IDLE: begin
            if (w_sof) begin
              r_state      <= CMD;
              r_busy       <= 1'b1;
              r_tx         <= REG_W'(status) << (REG_W - CMD_W);
              r_bitcnt     <= '0;
              r_first_seen <= 1'b0;
              r_word_done  <= 1'b0;
            end
          end
          CMD: begin
            if (w_sample) begin
              r_rx <= w_rx_next;
              if (r_bitcnt == CNT_W'(CMD_W - 1)) begin
                r_bitcnt    <= '0;
                r_addr      <= w_rx_next[ADDR_W-1:0];
                r_state     <= w_rx_next[RW_BIT] ? WR_DATA : RD_DATA;
                r_word_done <= ~w_rx_next[RW_BIT];
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          WR_DATA: begin
            if (w_sample) begin
              r_rx <= w_rx_next;
              if (r_bitcnt == CNT_W'(REG_W - 1)) begin
                r_bitcnt <= '0;
                r_data_o <= w_rx_next;
                r_dv     <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          RD_DATA: begin
            if (w_sample) begin
              if (r_bitcnt == CNT_W'(REG_W - 1)) begin
                r_bitcnt    <= '0;
                r_word_done <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso      = r_tx[REG_W-1];
  assign reg_addr      = r_addr;
  assign reg_data_o    = r_data_o;
  assign reg_data_o_dv = r_dv;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_burst.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_spi_reg_burst : directed self-checking bench for spi_reg_burst  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module tb_spi_reg_burst;

  localparam int H = 6;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic ena = 1'b1;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic spi_clk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic sel3 = 1'b0;
  logic [7:0] status = 8'h5A;

  int n_checks = 0;
  int n_fail = 0;

  wire logic       cs4 = sel3 ? 1'b1 : spi_cs_n;
  wire logic       cs3 = sel3 ? spi_cs_n : 1'b1;
  logic            miso4, miso3, dv4, dv3, busy4, busy3;
  logic [3:0]      addr4;
  logic [2:0]      addr3;
  logic [7:0]      rdata4, rdata3, wdata4, wdata3;
  wire logic       miso_sel = sel3 ? miso3 : miso4;

  // Register file stand-in: each address reads back addr*0x11.
  assign rdata4 = 8'(addr4) * 8'h11;
  assign rdata3 = 8'(addr3) * 8'h11;

  logic [3:0] dv_a4[$];
  logic [7:0] dv_d4[$];
  logic [2:0] dv_a3[$];
  logic [7:0] dv_d3[$];

  spi_reg_burst #(.ADDR_W(4), .REG_W(8), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rstb(rstb), .ena(ena), .cpol(cpol), .cpha(cpha),
    .spi_clk(spi_clk), .spi_cs_n(cs4), .spi_mosi(spi_mosi), .spi_miso(miso4),
    .reg_addr(addr4), .reg_data_i(rdata4), .reg_data_o(wdata4),
    .reg_data_o_dv(dv4), .status(status), .busy(busy4)
  );

  spi_reg_burst #(.ADDR_W(3), .REG_W(8), .SYNC_STAGES(2)) u_dut3 (
    .clk(clk), .rstb(rstb), .ena(ena), .cpol(cpol), .cpha(cpha),
    .spi_clk(spi_clk), .spi_cs_n(cs3), .spi_mosi(spi_mosi), .spi_miso(miso3),
    .reg_addr(addr3), .reg_data_i(rdata3), .reg_data_o(wdata3),
    .reg_data_o_dv(dv3), .status(status), .busy(busy3)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dv4 === 1'b1) begin dv_a4.push_back(addr4); dv_d4.push_back(wdata4); end
    if (dv3 === 1'b1) begin dv_a3.push_back(addr3); dv_d3.push_back(wdata3); end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_h();
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_begin(input logic pol, input logic pha);
    @(negedge clk);
    cpol = pol; cpha = pha; spi_clk = pol; spi_cs_n = 1'b1;
    wait_h();
    spi_cs_n = 1'b0;
    wait_h();
  endtask

  task automatic spi_bit(input logic b, output logic m);
    if (!cpha) begin
      spi_mosi = b; wait_h();
      m = miso_sel; spi_clk = ~cpol; wait_h();
      spi_clk = cpol;
    end else begin
      spi_clk = ~cpol; spi_mosi = b; wait_h();
      m = miso_sel; spi_clk = cpol; wait_h();
    end
  endtask

  task automatic spi_byte(input logic [7:0] v, output logic [7:0] r);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(v[i], m);
      r[i] = m;
    end
  endtask

  task automatic spi_end();
    wait_h();
    spi_cs_n = 1'b1;
    wait_h(); wait_h();
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (addr4 !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", addr4); end
    n_checks++; if (wdata4 !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %0h want 00", wdata4); end
    n_checks++; if (dv4 !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %0b want 0", dv4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy4); end
    n_checks++; if (miso4 !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %0b want 0", miso4); end
  endtask

  task automatic test_write(input logic pol, input logic pha);
    logic [7:0] r;
    logic [3:0] ea[2];
    logic [7:0] ed[2];
    int n0;
    ea[0] = 4'd2; ea[1] = 4'd3; ed[0] = 8'hA5; ed[1] = 8'h3C;
    sel3 = 1'b0;
    n0 = dv_a4.size();
    spi_begin(pol, pha);
    spi_byte(8'h82, r); spi_byte(8'hA5, r); spi_byte(8'h3C, r);
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL write_busy mode%0d: got %0b want 1", {pol, pha}, busy4); end
    spi_end();
    n_checks++;
    if (dv_a4.size() !== n0 + 2) begin
      n_fail++; $display("FAIL write_dv_count mode%0d: got %0d want %0d", {pol, pha}, dv_a4.size() - n0, 2);
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (n0 + i >= dv_a4.size() || dv_a4[n0+i] !== ea[i]) begin
        n_fail++; $display("FAIL write_dv_addr mode%0d word%0d: want %0h", {pol, pha}, i, ea[i]);
      end
      n_checks++;
      if (n0 + i >= dv_d4.size() || dv_d4[n0+i] !== ed[i]) begin
        n_fail++; $display("FAIL write_dv_data mode%0d word%0d: want %0h", {pol, pha}, i, ed[i]);
      end
    end
    n_checks++; if (addr4 !== 4'd4) begin n_fail++; $display("FAIL write_final_addr mode%0d: got %0h want 4", {pol, pha}, addr4); end
  endtask

  task automatic test_read(input logic pol, input logic pha);
    logic [7:0] r0, r1, r2;
    sel3 = 1'b0;
    spi_begin(pol, pha);
    spi_byte(8'h05, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2);
    spi_end();
    n_checks++; if (r0 !== 8'h5A) begin n_fail++; $display("FAIL read_status mode%0d: got %0h want 5a", {pol, pha}, r0); end
    n_checks++; if (r1 !== 8'h55) begin n_fail++; $display("FAIL read_word0 mode%0d: got %0h want 55", {pol, pha}, r1); end
    n_checks++; if (r2 !== 8'h66) begin n_fail++; $display("FAIL read_word1 mode%0d: got %0h want 66", {pol, pha}, r2); end
  endtask

  task automatic test_wrap();
    logic [7:0] r;
    logic [2:0] ea[3];
    logic [7:0] ed[3];
    ea[0] = 3'd6; ea[1] = 3'd7; ea[2] = 3'd0;
    ed[0] = 8'h11; ed[1] = 8'h22; ed[2] = 8'h33;
    sel3 = 1'b1;
    spi_begin(1'b0, 1'b0);
    spi_byte(8'h86, r); spi_byte(8'h11, r); spi_byte(8'h22, r); spi_byte(8'h33, r);
    spi_end();
    sel3 = 1'b0;
    n_checks++; if (dv_a3.size() !== 3) begin n_fail++; $display("FAIL wrap_dv_count: got %0d want 3", dv_a3.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= dv_a3.size() || dv_a3[i] !== ea[i] || dv_d3[i] !== ed[i]) begin
        n_fail++; $display("FAIL wrap_dv word%0d: want addr %0d data %0h", i, ea[i], ed[i]);
      end
    end
    n_checks++; if (addr3 !== 3'd1) begin n_fail++; $display("FAIL wrap_final_addr: got %0d want 1", addr3); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    logic m;
    logic [4:0] bits;
    int n0;
    bits = 5'b10110;
    sel3 = 1'b0;
    n0 = dv_a4.size();
    spi_begin(1'b0, 1'b0);
    spi_byte(8'h82, r);
    for (int i = 4; i >= 0; i--) spi_bit(bits[i], m);
    spi_end();
    n_checks++; if (dv_a4.size() !== n0) begin n_fail++; $display("FAIL abort_no_dv: got %0d pulses want 0", dv_a4.size() - n0); end
    n_checks++; if (wdata4 !== 8'h3C) begin n_fail++; $display("FAIL abort_data_kept: got %0h want 3c", wdata4); end
    n_checks++; if (addr4 !== 4'd2) begin n_fail++; $display("FAIL abort_addr_kept: got %0h want 2", addr4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", busy4); end
    n0 = dv_a4.size();
    spi_begin(1'b0, 1'b0);
    spi_byte(8'h83, r); spi_byte(8'h77, r);
    spi_end();
    n_checks++;
    if (dv_a4.size() !== n0 + 1 || dv_a4[n0] !== 4'd3 || dv_d4[n0] !== 8'h77) begin
      n_fail++; $display("FAIL abort_next_frame: got %0d pulses, want one at addr 3 data 77", dv_a4.size() - n0);
    end
    n_checks++; if (addr4 !== 4'd4) begin n_fail++; $display("FAIL abort_next_addr: got %0h want 4", addr4); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r0, r1, r2;
    logic m;
    sel3 = 1'b0;
    spi_begin(1'b0, 1'b0);
    spi_byte(8'h05, r0);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, m);
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %0b want 1", busy4); end
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (addr4 !== 4'd0) begin n_fail++; $display("FAIL midreset_addr: got %0h want 0", addr4); end
    n_checks++; if (wdata4 !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %0h want 00", wdata4); end
    n_checks++; if (dv4 !== 1'b0) begin n_fail++; $display("FAIL midreset_dv: got %0b want 0", dv4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %0b want 0", busy4); end
    n_checks++; if (miso4 !== 1'b0) begin n_fail++; $display("FAIL midreset_miso: got %0b want 0", miso4); end
    rstb = 1'b1;
    wait_h();
    spi_cs_n = 1'b1;
    wait_h();
    spi_begin(1'b0, 1'b0);
    spi_byte(8'h05, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2);
    spi_end();
    n_checks++;
    if (r0 !== 8'h5A || r1 !== 8'h55 || r2 !== 8'h66) begin
      n_fail++; $display("FAIL midreset_resync: got %0h %0h %0h want 5a 55 66", r0, r1, r2);
    end
  endtask

  task automatic test_ena();
    logic [7:0] r;
    logic m;
    logic [5:0] tail;
    int n0;
    tail = 6'b110011;
    sel3 = 1'b0;
    n0 = dv_a4.size();
    spi_begin(1'b0, 1'b0);
    spi_byte(8'h81, r);
    spi_bit(1'b1, m); spi_bit(1'b0, m);
    wait_h();
    ena = 1'b0;
    for (int i = 0; i < 4; i++) begin
      spi_mosi = i[0];
      spi_clk = ~spi_clk;
      wait_h();
    end
    n_checks++; if (addr4 !== 4'd1) begin n_fail++; $display("FAIL ena_hold_addr: got %0h want 1", addr4); end
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL ena_hold_busy: got %0b want 1", busy4); end
    n_checks++; if (wdata4 !== 8'h00) begin n_fail++; $display("FAIL ena_hold_data: got %0h want 00", wdata4); end
    n_checks++; if (dv_a4.size() !== n0) begin n_fail++; $display("FAIL ena_hold_dv: got %0d pulses want 0", dv_a4.size() - n0); end
    ena = 1'b1;
    wait_h();
    for (int i = 5; i >= 0; i--) spi_bit(tail[i], m);
    spi_end();
    n_checks++;
    if (dv_a4.size() !== n0 + 1 || dv_a4[n0] !== 4'd1 || dv_d4[n0] !== 8'hB3) begin
      n_fail++; $display("FAIL ena_resume_word: got %0d pulses, want one at addr 1 data b3", dv_a4.size() - n0);
    end
    n_checks++; if (addr4 !== 4'd2) begin n_fail++; $display("FAIL ena_resume_addr: got %0h want 2", addr4); end
  endtask

  initial begin
    test_reset();
    for (int m = 0; m < 4; m++) begin
      test_write(m[1], m[0]);
      test_read(m[1], m[0]);
    end
    test_wrap();
    test_abort();
    test_reset_mid();
    test_ena();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
